mem_refill_engine: RTL and testbench

//  Memory-side refill engine; sits directly upstream of the cache miss handler's memory interface.
//  - Accepts one block request (16-bit block address) per miss.
//  - Reads 8 x 40-bit beats from a fixed-latency backing memory.
//  - Streams the beats, in order, on a valid/ready link that feeds the miss handler's mem_if data input.
//  - Output FIFO plus read credits: no beat is ever dropped under backpressure or halt.

---
 rtl/mem_refill_engine.sv | 200 ++++++++++++++++++++
 tb/tb_mem_refill_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_engine.sv
// -----------------------------------------------------------------------------
// mem_refill_engine
//   Memory-side refill engine for the cache miss handler. It accepts one block
//   request, reads BEATS words from a fixed-latency backing memory and streams
//   them in order over a valid/ready link. An output FIFO plus read credits
//   make sure no beat is lost under backpressure or a global halt.
//
// Ports
//   clk               clock, all state on the rising edge
//   arst_n            synchronous active-low reset
//   i_halt            global stall (blocks issue, output valid and acceptance)
//   i_mem_req_addr    block address {tag, set, offset}
//   i_mem_req_valid   request valid
//   o_req_ready       high only in IDLE while not halted
//   o_mem_data        FIFO head beat
//   o_mem_data_valid  FIFO non-empty and not halted
//   i_mem_ready       consumer accepts a beat
//   o_bm_addr         backing-memory word address {block, beat index}
//   o_bm_rd_en        backing-memory read strobe
//   i_bm_rdata        read data, RD_LATENCY cycles after the strobe
//   o_burst_done      one-cycle pulse on the transfer of the last beat
//   o_busy            engine not in IDLE
// -----------------------------------------------------------------------------
module mem_refill_engine #(
    parameter int REQ_ADDR_W     = 16,
    parameter int DATA_W         = 40,
    parameter int BEATS          = 8,
    parameter int BM_ADDR_W      = 15,
    parameter int RD_LATENCY     = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int CRITICAL_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic [REQ_ADDR_W-1:0] i_mem_req_addr,
    input  logic                  i_mem_req_valid,
    output logic                  o_req_ready,
    output logic [DATA_W-1:0]     o_mem_data,
    output logic                  o_mem_data_valid,
    input  logic                  i_mem_ready,
    output logic [BM_ADDR_W-1:0]  o_bm_addr,
    output logic                  o_bm_rd_en,
    input  logic [DATA_W-1:0]     i_bm_rdata,
    output logic                  o_burst_done,
    output logic                  o_busy
);

    localparam int OFS_W = 4;                          // offset bits of the request
    localparam int TAG_W = REQ_ADDR_W - OFS_W;         // block part kept for the burst
    localparam int IDX_W = $clog2(BEATS);
    localparam int ISS_W = $clog2(BEATS + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int INF_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;
    logic [ISS_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]    xfer_cnt_q, xfer_cnt_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic [INF_W-1:0]    inflight;
    logic                credit_ok;
    logic                req_ready, rd_en, accept, push, pop, done, data_valid;
    logic                unused_bits;

    assign unused_bits = i_mem_req_addr[0];

    // Reads in flight, counted from the return-tracking pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe_q[i]);
        end
    end

    // A read may issue only if the FIFO has room for it once every read already
    // in flight has landed; this is what makes overflow impossible.
    assign credit_ok = ({1'b0, fifo_count_q} + (CNT_W + 1)'(inflight)) < DEPTH_L;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_BURST;
            ST_BURST: if (rd_en && issue_cnt_q == ISS_W'(BEATS - 1)) state_d = ST_DRAIN;
            ST_DRAIN: if (done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready        = (state_q == ST_IDLE) && !i_halt;
        accept           = req_ready && i_mem_req_valid;
        rd_en            = (state_q == ST_BURST) && !i_halt && credit_ok;
        data_valid       = (fifo_count_q != '0) && !i_halt;
        pop              = data_valid && i_mem_ready;
        push             = pipe_q[RD_LATENCY-1];
        done             = pop && (xfer_cnt_q == IDX_W'(BEATS - 1));
        o_req_ready      = req_ready;
        o_bm_rd_en       = rd_en;
        o_bm_addr        = {tag_q, beat_idx_q};
        o_mem_data_valid = data_valid;
        // Gated so the data bus reads 0 whenever the FIFO is empty.
        o_mem_data       = (fifo_count_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
        o_burst_done     = done;
        o_busy           = (state_q != ST_IDLE);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        tag_d        = tag_q;
        beat_idx_d   = beat_idx_q;
        issue_cnt_d  = issue_cnt_q;
        xfer_cnt_d   = xfer_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (accept) begin
            tag_d       = i_mem_req_addr[REQ_ADDR_W-1:OFS_W];
            beat_idx_d  = (CRITICAL_FIRST != 0) ? i_mem_req_addr[OFS_W-1:OFS_W-IDX_W] : '0;
            issue_cnt_d = '0;
            xfer_cnt_d  = '0;
        end

        if (rd_en) begin
            beat_idx_d  = beat_idx_q + 1'b1;   // natural wrap mod BEATS
            issue_cnt_d = issue_cnt_q + 1'b1;
        end

        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
            rd_ptr_d   = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase

        // The pipe keeps shifting during a halt so issued reads always land.
        pipe_d = (pipe_q << 1) | RD_LATENCY'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            tag_q        <= '0;
            beat_idx_q   <= '0;
            issue_cnt_q  <= '0;
            xfer_cnt_q   <= '0;
            pipe_q       <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            tag_q        <= tag_d;
            beat_idx_q   <= beat_idx_d;
            issue_cnt_q  <= issue_cnt_d;
            xfer_cnt_q   <= xfer_cnt_d;
            pipe_q       <= pipe_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage is small, so it lives in registers and the head is read
    // combinationally; contents need no reset because the count gates them.
    always_ff @(posedge clk) begin
        if (arst_n && push) begin
            fifo_mem_q[wr_ptr_q] <= i_bm_rdata;
        end
    end

endmodule

// File: tb/tb_mem_refill_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_refill_engine
//   Drives two engines in lockstep: index 0 with default parameters and index 1
//   with critical-word-first ordering. Each has its own backing-memory model
//   whose data is a fixed function of the word address. A negedge monitor
//   scores every read address and every transferred beat against queues filled
//   when a request is accepted; directed steps check cycle timing.
// -----------------------------------------------------------------------------
module tb_mem_refill_engine;

    logic        clk = 1'b0;
    logic        arst_n, halt, req_valid, mem_ready;
    logic [15:0] req_addr;
    logic        started = 1'b0;

    logic        req_ready  [2];
    logic        data_valid [2];
    logic        rd_en      [2];
    logic        burst_done [2];
    logic        busy       [2];
    logic [39:0] mem_data   [2];
    logic [14:0] bm_addr    [2];

    int tests = 0;
    int fails = 0;

    logic [14:0] exp_addr_q [2][$];
    logic [39:0] exp_data_q [2][$];
    int          issued_n   [2];
    int          popped_n   [2];
    logic        stall_prev [2];
    logic [39:0] data_prev  [2];

    always #5 clk = ~clk;

    function automatic logic [39:0] beat_word(input logic [14:0] a);
        return {5'h15, a, 5'h0A, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic        bm_v_q;
            logic [14:0] bm_a_q;
            logic [39:0] rdata_q;

            mem_refill_engine #(.CRITICAL_FIRST(gi)) u_dut (
                .clk              (clk),
                .arst_n           (arst_n),
                .i_halt           (halt),
                .i_mem_req_addr   (req_addr),
                .i_mem_req_valid  (req_valid),
                .o_req_ready      (req_ready[gi]),
                .o_mem_data       (mem_data[gi]),
                .o_mem_data_valid (data_valid[gi]),
                .i_mem_ready      (mem_ready),
                .o_bm_addr        (bm_addr[gi]),
                .o_bm_rd_en       (rd_en[gi]),
                .i_bm_rdata       (rdata_q),
                .o_burst_done     (burst_done[gi]),
                .o_busy           (busy[gi])
            );

            // Two-cycle memory; returns noise whenever no read is due.
            always @(posedge clk) begin
                bm_v_q  <= rd_en[gi];
                bm_a_q  <= bm_addr[gi];
                rdata_q <= bm_v_q ? beat_word(bm_a_q) : {8'($urandom), $urandom};
            end
        end
    endgenerate

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [2:0]  first_idx;
        logic [14:0] a;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                if (req_valid && req_ready[d]) begin
                    first_idx = (d == 1) ? req_addr[3:1] : 3'd0;
                    for (int b = 0; b < 8; b++) begin
                        a = {req_addr[15:4], 3'(first_idx + 3'(b))};
                        exp_addr_q[d].push_back(a);
                        exp_data_q[d].push_back(beat_word(a));
                    end
                    issued_n[d] = 0;
                    popped_n[d] = 0;
                end
                if (rd_en[d]) begin
                    if (exp_addr_q[d].size() == 0)
                        chk($sformatf("extra_read[%0d]", d), 64'(1), 64'(0));
                    else
                        chk($sformatf("bm_addr[%0d]", d), 64'(bm_addr[d]), 64'(exp_addr_q[d].pop_front()));
                    chk($sformatf("credit[%0d]", d), 64'((issued_n[d] - popped_n[d]) < 4), 64'(1));
                    issued_n[d]++;
                end
                if (data_valid[d] && mem_ready) begin
                    if (exp_data_q[d].size() == 0)
                        chk($sformatf("extra_beat[%0d]", d), 64'(1), 64'(0));
                    else
                        chk($sformatf("beat_data[%0d]", d), 64'(mem_data[d]), 64'(exp_data_q[d].pop_front()));
                    chk($sformatf("burst_done[%0d]", d), 64'(burst_done[d]), 64'(popped_n[d] == 7));
                    popped_n[d]++;
                end else begin
                    chk($sformatf("done_quiet[%0d]", d), 64'(burst_done[d]), 64'(0));
                end
                if (stall_prev[d] && data_valid[d])
                    chk($sformatf("data_hold[%0d]", d), 64'(mem_data[d]), 64'(data_prev[d]));
                stall_prev[d] = data_valid[d] && !mem_ready;
                data_prev[d]  = mem_data[d];
                if (!arst_n) begin
                    exp_addr_q[d].delete();
                    exp_data_q[d].delete();
                    issued_n[d]   = 0;
                    popped_n[d]   = 0;
                    stall_prev[d] = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy[0] || busy[1]) && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(busy[0] | busy[1]), 64'(0));
    endtask

    task automatic end_burst(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_xfers[%0d]", tag, d), 64'(popped_n[d]), 64'(8));
            chk($sformatf("%s_left[%0d]", tag, d), 64'(exp_data_q[d].size() + exp_addr_q[d].size()), 64'(0));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_req_ready[%0d]", tag, d), 64'(req_ready[d]), 64'(1));
            chk($sformatf("%s_busy[%0d]", tag, d), 64'(busy[d]), 64'(0));
            chk($sformatf("%s_valid[%0d]", tag, d), 64'(data_valid[d]), 64'(0));
            chk($sformatf("%s_rd_en[%0d]", tag, d), 64'(rd_en[d]), 64'(0));
            chk($sformatf("%s_done[%0d]", tag, d), 64'(burst_done[d]), 64'(0));
            chk($sformatf("%s_bm_addr[%0d]", tag, d), 64'(bm_addr[d]), 64'(0));
            chk($sformatf("%s_data[%0d]", tag, d), 64'(mem_data[d]), 64'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0; halt = 1'b0; req_valid = 1'b0; req_addr = '0; mem_ready = 1'b1;
        step();
        started = 1'b1;
        step();
        @(negedge clk);
        chk_idle_outputs("reset");
        step();
        arst_n = 1'b1;

        // T1 (and T2 on index 1): nominal burst, 0xAB35, consumer always ready
        step();
        req_valid = 1'b1; req_addr = 16'hAB35;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("T1_accept[%0d]", d), 64'(req_ready[d]), 64'(1));
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("T1_rd_en[%0d]@%0d", d, k), 64'(rd_en[d]), 64'(k <= 8));
                chk($sformatf("T1_valid[%0d]@%0d", d, k), 64'(data_valid[d]), 64'(k >= 4 && k <= 11));
                chk($sformatf("T1_done[%0d]@%0d", d, k), 64'(burst_done[d]), 64'(k == 11));
                chk($sformatf("T1_req_ready[%0d]@%0d", d, k), 64'(req_ready[d]), 64'(k >= 12));
                chk($sformatf("T1_busy[%0d]@%0d", d, k), 64'(busy[d]), 64'(k <= 11));
            end
            if (k == 1) chk("T2_first_addr", 64'(bm_addr[1]), 64'(15'h559A));
            if (k == 7) chk("T2_wrap_addr", 64'(bm_addr[1]), 64'(15'h5598));
        end
        wait_idle(20);
        end_burst("T1");

        // T3: consumer stalls for cycles 5-12
        step();
        req_valid = 1'b1; req_addr = 16'hAB35;
        @(negedge clk);
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            mem_ready = !(k >= 5 && k <= 12);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (k == 5) chk($sformatf("T3_fifth_issue[%0d]", d), 64'(rd_en[d]), 64'(1));
                if (k == 7) chk($sformatf("T3_rd_stall[%0d]", d), 64'(rd_en[d]), 64'(0));
                if (k == 9) chk($sformatf("T3_valid_held[%0d]", d), 64'(data_valid[d]), 64'(1));
            end
        end
        mem_ready = 1'b1;
        wait_idle(20);
        end_burst("T3");

        // T4: halt for cycles 4-6, right after the third issue
        step();
        req_valid = 1'b1; req_addr = 16'hAB35;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            halt = (k >= 4 && k <= 6);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (halt) begin
                    chk($sformatf("T4_halt_rd[%0d]@%0d", d, k), 64'(rd_en[d]), 64'(0));
                    chk($sformatf("T4_halt_valid[%0d]@%0d", d, k), 64'(data_valid[d]), 64'(0));
                end
                if (k == 7) chk($sformatf("T4_resume_rd[%0d]", d), 64'(rd_en[d]), 64'(1));
            end
            if (k == 7) begin
                chk("T4_resume_addr[0]", 64'(bm_addr[0]), 64'(15'h559B));
                chk("T4_resume_addr[1]", 64'(bm_addr[1]), 64'(15'h559D));
            end
        end
        halt = 1'b0;
        wait_idle(20);
        end_burst("T4");

        // T5: reset one cycle after the third transfer, then a clean burst
        step();
        req_valid = 1'b1; req_addr = 16'hAB35;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) req_valid = 1'b0;
            if (k == 7) arst_n = 1'b0;
            if (k == 8) arst_n = 1'b1;
            @(negedge clk);
            if (k == 8) chk_idle_outputs("T5_reset");
            for (int d = 0; d < 2; d++)
                if (k >= 8) chk($sformatf("T5_late[%0d]@%0d", d, k), 64'(data_valid[d]), 64'(0));
        end
        step();
        req_valid = 1'b1; req_addr = 16'h1200;
        @(negedge clk);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("T5_new_addr[%0d]", d), 64'(bm_addr[d]), 64'(15'h0900));
        wait_idle(20);
        end_burst("T5");

        // T6: request held high through a burst with a changed address
        step();
        req_valid = 1'b1; req_addr = 16'h4C70;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) req_addr = 16'h7E1C;
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk($sformatf("T6_req_ready[%0d]@%0d", d, k), 64'(req_ready[d]), 64'(k == 12));
        end
        step();
        req_valid = 1'b0;
        wait_idle(20);
        end_burst("T6");

        // Halt blocks acceptance in IDLE
        step();
        halt = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("halt_req_ready[%0d]", d), 64'(req_ready[d]), 64'(0));
        step();
        halt = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
